// File: rtl/mmio_fifo_responder_pkg.sv
// Shared constants for the MMIO byte FIFO responder: register offsets and
// bit positions inside the STATUS and CTRL registers.
package mmio_fifo_responder_pkg;

    localparam int unsigned REG_DATA   = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_POP    = 2;
    localparam int unsigned REG_CTRL   = 3;
    localparam int unsigned REG_THRESH = 4;
    localparam int unsigned REG_CSUM   = 5;

    localparam int unsigned ST_OVF     = 7;
    localparam int unsigned ST_UNF     = 6;
    localparam int unsigned ST_FULL    = 5;
    localparam int unsigned ST_EMPTY   = 4;
    localparam int unsigned ST_CNT_LSB = 0;
    localparam int unsigned ST_CNT_W   = 4;

    localparam int unsigned CTRL_FLUSH    = 0;
    localparam int unsigned CTRL_CLRFLAGS = 1;

endpackage

// File: rtl/mmio_fifo_store.sv
// FIFO entry storage: registered write port, asynchronous read port, no reset.
module mmio_fifo_store #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmio_fifo_responder.sv
// Memory-mapped byte FIFO peripheral on the CPU data bus: push/peek/pop,
// sticky status flags, running checksum and a level interrupt.
module mmio_fifo_responder
    import mmio_fifo_responder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADR_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADR_BITS-1:0] ADR,
    input  logic                ADR_MATCH,
    input  logic                WRITE,
    input  logic [WIDTH-1:0]    DATA_IN,
    output logic [WIDTH-1:0]    DATA_OUT,
    output logic                IRQ
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [WIDTH-1:0] thresh_q, thresh_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full, empty;
    logic             wr_en, push, pop, ctrl_wr, thresh_wr;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] status;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Bus decode: one operation per cycle, so at most one strobe is active.
    assign wr_en     = WRITE && ADR_MATCH;
    assign push      = wr_en && (ADR == ADR_BITS'(REG_DATA));
    assign pop       = wr_en && (ADR == ADR_BITS'(REG_POP));
    assign ctrl_wr   = wr_en && (ADR == ADR_BITS'(REG_CTRL));
    assign thresh_wr = wr_en && (ADR == ADR_BITS'(REG_THRESH));

    mmio_fifo_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_store (
        .clk     (clk),
        .we_i    (push && !full),
        .waddr_i (wr_ptr_q),
        .wdata_i (DATA_IN),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Next-state for pointers, occupancy, checksum, flags and threshold.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        csum_d   = csum_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_q + CNT_W'(1);
                csum_d   = csum_q + DATA_IN;
            end
        end

        if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = count_q - CNT_W'(1);
            end
        end

        if (ctrl_wr) begin
            if (DATA_IN[CTRL_FLUSH]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                csum_d   = '0;
            end
            if (DATA_IN[CTRL_CLRFLAGS]) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
        end

        if (thresh_wr) begin
            thresh_d = DATA_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            csum_q   <= '0;
            thresh_q <= WIDTH'(DEPTH);
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            csum_q   <= csum_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_comb begin
        status                            = '0;
        status[ST_OVF]                    = ovf_q;
        status[ST_UNF]                    = unf_q;
        status[ST_FULL]                   = full;
        status[ST_EMPTY]                  = empty;
        status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(count_q);
    end

    // Side-effect-free read mux; window miss reads as zero.
    always_comb begin
        DATA_OUT = '0;
        if (ADR_MATCH) begin
            case (ADR)
                ADR_BITS'(REG_DATA):   DATA_OUT = empty ? '0 : head;
                ADR_BITS'(REG_STATUS): DATA_OUT = status;
                ADR_BITS'(REG_THRESH): DATA_OUT = thresh_q;
                ADR_BITS'(REG_CSUM):   DATA_OUT = csum_q;
                default:               DATA_OUT = '0;
            endcase
        end
    end

    assign IRQ = ovf_q | ((thresh_q != '0) && (WIDTH'(count_q) >= thresh_q));

endmodule

// File: tb/tb_mmio_fifo_responder.sv
// Scoreboard bench for mmio_fifo_responder: directed register-map scenarios
// followed by randomized bus traffic checked against a queue-based model.
module tb_mmio_fifo_responder;

    logic       clk;
    logic       reset;
    logic [2:0] ADR;
    logic       ADR_MATCH;
    logic       WRITE;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       IRQ;

    mmio_fifo_responder dut (
        .clk       (clk),
        .reset     (reset),
        .ADR       (ADR),
        .ADR_MATCH (ADR_MATCH),
        .WRITE     (WRITE),
        .DATA_IN   (DATA_IN),
        .DATA_OUT  (DATA_OUT),
        .IRQ       (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: FIFO as a queue plus flag/register variables.
    logic [7:0] mq[$];
    bit         m_ovf, m_unf;
    logic [7:0] m_thresh, m_csum;

    // Scoreboard queues and monitor handshake.
    logic [7:0] exp_d[$];
    bit         exp_i[$];
    int         exp_a[$];
    bit         rd_req;
    bit         done, mon_done;
    int         checks, errors;

    task automatic model_reset();
        mq.delete();
        m_ovf    = 0;
        m_unf    = 0;
        m_thresh = 8'd8;
        m_csum   = 8'd0;
    endtask

    task automatic model_write(input int adr, input logic [7:0] d);
        case (adr)
            0: if (mq.size() == 8) m_ovf = 1;
               else begin mq.push_back(d); m_csum = m_csum + d; end
            2: if (mq.size() == 0) m_unf = 1;
               else void'(mq.pop_front());
            3: begin
                if (d[0]) begin mq.delete(); m_csum = 8'd0; end
                if (d[1]) begin m_ovf = 0; m_unf = 0; end
            end
            4: m_thresh = d;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] model_read(input int adr);
        logic [3:0] cnt;
        cnt = 4'(mq.size());
        case (adr)
            0: return (mq.size() == 0) ? 8'd0 : mq[0];
            1: return {m_ovf, m_unf, mq.size() == 8, mq.size() == 0, cnt};
            4: return m_thresh;
            5: return m_csum;
            default: return 8'd0;
        endcase
    endfunction

    function automatic bit model_irq();
        return m_ovf || (m_thresh != 0 && mq.size() >= int'(m_thresh));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int adr, input logic [7:0] d, input bit match);
        tick();
        reset     = 1'b0;
        ADR       = 3'(adr);
        ADR_MATCH = match;
        WRITE     = 1'b1;
        DATA_IN   = d;
        rd_req    = 0;
        if (match) model_write(adr, d);
    endtask

    task automatic push(input logic [7:0] d);
        do_write(0, d, 1'b1);
    endtask

    task automatic pop();
        do_write(2, 8'($urandom), 1'b1);
    endtask

    // Read whose expectation comes from the model.
    task automatic do_read(input int adr, input bit match);
        tick();
        reset     = 1'b0;
        ADR       = 3'(adr);
        ADR_MATCH = match;
        WRITE     = 1'b0;
        DATA_IN   = 8'($urandom);
        exp_d.push_back(match ? model_read(adr) : 8'd0);
        exp_i.push_back(model_irq());
        exp_a.push_back(adr);
        rd_req    = 1;
    endtask

    // Read whose expectation is a hand-derived constant.
    task automatic read_exp(input int adr, input logic [7:0] val, input bit irq);
        tick();
        reset     = 1'b0;
        ADR       = 3'(adr);
        ADR_MATCH = 1'b1;
        WRITE     = 1'b0;
        DATA_IN   = 8'd0;
        exp_d.push_back(val);
        exp_i.push_back(irq);
        exp_a.push_back(adr);
        rd_req    = 1;
    endtask

    task automatic idle();
        tick();
        reset     = 1'b0;
        ADR_MATCH = 1'b0;
        WRITE     = 1'b0;
        rd_req    = 0;
    endtask

    // Monitor: compares every presented read against the scoreboard head.
    always @(negedge clk) begin
        if (rd_req) begin
            if (exp_d.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underrun: read presented with no expectation");
            end else begin
                logic [7:0] ed;
                bit         ei;
                int         ea;
                ed = exp_d.pop_front();
                ei = exp_i.pop_front();
                ea = exp_a.pop_front();
                checks += 2;
                if (DATA_OUT !== ed) begin
                    errors++;
                    $display("FAIL read_adr%0d @%0t: got 0x%02h expected 0x%02h", ea, $time, DATA_OUT, ed);
                end
                if (IRQ !== ei) begin
                    errors++;
                    $display("FAIL irq_at_adr%0d @%0t: got %0b expected %0b", ea, $time, IRQ, ei);
                end
            end
        end
        if (done && !mon_done) begin
            checks++;
            if (exp_d.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_d.size());
            end
            mon_done = 1;
        end
    end

    initial begin
        reset     = 1'b1;
        ADR       = '0;
        ADR_MATCH = 1'b0;
        WRITE     = 1'b0;
        DATA_IN   = '0;
        rd_req    = 0;
        done      = 0;
        mon_done  = 0;
        checks    = 0;
        errors    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        read_exp(1, 8'h10, 1'b0);
        read_exp(4, 8'h08, 1'b0);
        read_exp(5, 8'h00, 1'b0);
        do_read(0, 1'b0);

        // Fill, then overflow
        for (int i = 0; i < 7; i++) push(8'(8'h11 + i));
        read_exp(1, 8'h07, 1'b0);
        push(8'h18);
        read_exp(1, 8'h28, 1'b1);
        read_exp(5, 8'hA4, 1'b1);
        push(8'h99);
        read_exp(1, 8'hA8, 1'b1);
        read_exp(5, 8'hA4, 1'b1);
        read_exp(0, 8'h11, 1'b1);

        // Drain, underflow, clear flags
        pop();
        read_exp(0, 8'h12, 1'b1);
        for (int i = 0; i < 7; i++) pop();
        read_exp(1, 8'h90, 1'b1);
        read_exp(0, 8'h00, 1'b1);
        pop();
        read_exp(1, 8'hD0, 1'b1);
        do_write(3, 8'h02, 1'b1);
        read_exp(1, 8'h10, 1'b0);

        // Pointer wrap-around
        for (int i = 0; i < 5; i++) push(8'($urandom));
        for (int i = 0; i < 5; i++) pop();
        for (int i = 0; i < 6; i++) push(8'(8'h21 + i));
        for (int i = 0; i < 6; i++) begin
            read_exp(0, 8'(8'h21 + i), 1'b0);
            pop();
        end
        read_exp(1, 8'h10, 1'b0);
        do_read(5, 1'b1);

        // Threshold interrupt
        do_write(4, 8'd3, 1'b1);
        read_exp(4, 8'h03, 1'b0);
        push(8'h01);
        push(8'h02);
        read_exp(1, 8'h02, 1'b0);
        push(8'h03);
        read_exp(1, 8'h03, 1'b1);
        pop();
        read_exp(1, 8'h02, 1'b0);
        for (int i = 0; i < 6; i++) push(8'($urandom));
        read_exp(1, 8'h28, 1'b1);
        do_write(4, 8'd0, 1'b1);
        read_exp(1, 8'h28, 1'b0);

        // Flush, window miss, reset coincident with a push
        do_write(3, 8'h01, 1'b1);
        read_exp(1, 8'h10, 1'b0);
        read_exp(5, 8'h00, 1'b0);
        read_exp(4, 8'h00, 1'b0);
        do_write(0, 8'h55, 1'b0);
        read_exp(1, 8'h10, 1'b0);
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        read_exp(1, 8'h03, 1'b0);
        tick();
        reset     = 1'b1;
        ADR       = 3'd0;
        ADR_MATCH = 1'b1;
        WRITE     = 1'b1;
        DATA_IN   = 8'h77;
        rd_req    = 0;
        model_reset();
        read_exp(1, 8'h10, 1'b0);
        read_exp(5, 8'h00, 1'b0);
        read_exp(4, 8'h08, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            int r;
            bit m;
            r = int'($urandom_range(0, 99));
            m = ($urandom_range(0, 9) != 0);
            if (r < 30)      do_write(0, 8'($urandom), m);
            else if (r < 45) do_write(2, 8'($urandom), m);
            else if (r < 48) do_write(3, 8'($urandom_range(0, 3)), m);
            else if (r < 52) do_write(4, 8'($urandom_range(0, 10)), m);
            else if (r < 54) do_write(int'($urandom_range(5, 7)), 8'($urandom), m);
            else             do_read(int'($urandom_range(0, 7)), m);
        end

        idle();
        done = 1;
        for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: monitor did not drain within 20 cycles");
            $fatal(1, "monitor timeout");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
